// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// dcache_pkg : shared types, default geometry and byte-lane helpers for dcache
// Revision   : 1.0
// ============================================================================
package dcache_pkg;

  localparam int DEF_INDEX_BITS = 3;
  localparam int DEF_ADDR_W     = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    return word[8*lane +: 8];
  endfunction

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
    logic [31:0] r;
    r = word;
    r[8*lane +: 8] = b;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// dcache_array : one-word-per-line tag/data/valid/dirty store,
//                combinational read, synchronous write
// Revision     : 1.0
// ============================================================================
module dcache_array import dcache_pkg::*; #(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_W      = DEF_ADDR_W - DEF_INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic                  wr_dirty,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES];

  // Only the status bits are reset; tag/data are don't-care while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      valid[index] <= 1'b1;
      dirty[index] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[index] <= wr_tag;
      data[index] <= wr_data;
    end
  end

  assign rd_valid = valid[index];
  assign rd_dirty = dirty[index];
  assign rd_tag   = tags[index];
  assign rd_data  = data[index];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// dcache_ctrl : direct-mapped write-back/write-allocate data cache controller.
//               Optional hit/miss counters with `define DCACHE_STATS_EN.
// Revision    : 1.0
// ============================================================================
module dcache_ctrl import dcache_pkg::*; #(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_is_word,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  state_t state, state_nx;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            lane;
  logic                  line_valid, line_dirty;
  logic [TAG_W-1:0]      line_tag;
  logic [31:0]           line_data;
  logic                  hit, miss, ack;
  logic                  wr_en, wr_dirty;
  logic [TAG_W-1:0]      wr_tag;
  logic [31:0]           wr_data;

  assign index = cpu_addr[INDEX_BITS+1:2];
  assign tag   = cpu_addr[ADDR_W-1:INDEX_BITS+2];
  assign lane  = cpu_addr[1:0];
  assign hit   = line_valid && (line_tag == tag);
  assign miss  = (state == IDLE) && cpu_req && !hit;
  assign ack   = mem_ack && mem_req;

  dcache_array #(.INDEX_BITS(INDEX_BITS), .TAG_W(TAG_W)) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .index    (index),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (miss) state_nx = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (ack)  state_nx = ALLOCATE;
      ALLOCATE:  if (ack)  state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    wr_en     = 1'b0;
    wr_dirty  = 1'b0;
    wr_tag    = line_tag;
    wr_data   = line_data;
    case (state)
      IDLE: begin
        cpu_ready = !cpu_req || hit;
        if (cpu_req && hit) begin
          if (cpu_we) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            wr_data  = cpu_is_word ? cpu_wdata : merge_byte(line_data, lane, cpu_wdata[7:0]);
          end else begin
            cpu_rdata = cpu_is_word ? line_data : sext8(lane_byte(line_data, lane));
          end
        end
      end
      WRITEBACK: if (ack) wr_en = 1'b1;
      ALLOCATE: if (ack) begin
        wr_en   = 1'b1;
        wr_tag  = tag;
        wr_data = mem_rdata;
      end
      default: ;
    endcase
  end

  // Memory port is registered; a write-back ack chains straight into the refill read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (miss) begin
          mem_req <= 1'b1;
          if (line_valid && line_dirty) begin
            mem_we    <= 1'b1;
            mem_addr  <= {line_tag, index, 2'b00};
            mem_wdata <= line_data;
          end else begin
            mem_we   <= 1'b0;
            mem_addr <= {tag, index, 2'b00};
          end
        end
        WRITEBACK: if (ack) begin
          mem_we   <= 1'b0;
          mem_addr <= {tag, index, 2'b00};
        end
        ALLOCATE: if (ack) mem_req <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic replay;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      replay     <= 1'b0;
    end else begin
      replay <= (state == ALLOCATE) && ack;
      if (miss) miss_count <= miss_count + 32'd1;
      if ((state == IDLE) && cpu_req && hit && !replay) hit_count <= hit_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
